zslot_pulse_binner: RTL and testbench
=====================================

Name: zslot_pulse_binner

Overview:
- Consumer end of the tick interface. Takes the gap tick (333 us slot boundary) and the resample tick (new acquisition window) and counts photon-detector pulses in each slot.
- Emits one {slot index, count} word per slot over a valid/ready handshake to the block-RAM frame writer.
- A frame is 60 slots, which is 20 ms at 50 Hz.
- Sits between the tick trigger and the block-RAM writer, in the pulse-counter path.

Parameters:
- SLOTS_PER_FRAME, 60, slots per frame; the slot index wraps here.
- CNT_W, 16, width of the per-slot pulse counter.
- IDX_W, 6, width of the slot index; must satisfy 2^IDX_W >= SLOTS_PER_FRAME.
- SYNC_STAGES, 2, number of flip-flops in the pulse-input synchronizer.

Ports:
- iClk  in  1  100 MHz system clock.
- iRst_N  in  1  asynchronous active-low reset.
- iPulse  in  1  asynchronous photon-detector pulse, active high, minimum width 2 clocks.
- iTickGap  in  1  one-clock slot-boundary tick.
- iTickReSample  in  1  one-clock start-of-acquisition tick.
- oSlotData  out  IDX_W+CNT_W  {slot index, count}, with the index in the MSBs.
- oSlotValid  out  1  oSlotData is valid.
- iSlotReady  in  1  downstream accepts the word when oSlotValid and iSlotReady are both high.
- oFrameDone  out  1  one-clock pulse after the last slot of a frame is emitted.
- oBusy  out  1  high while in RUN.
- oOverflow  out  1  sticky flag: a slot word was dropped.
- oSat  out  1  sticky flag: a slot count saturated.

Behaviour:
- Reset (async, iRst_N=0):
  - all outputs 0, state IDLE;
  - counter, slot index and synchronizer flip-flops cleared.
  - Reset mid-frame discards all partial data; no word is emitted.
- Pulse path:
  - SYNC_STAGES flip-flop synchronizer, then rising-edge detect on the synchronized signal.
  - One edge = one count. Edge-detect latency is SYNC_STAGES+1 clocks from the iPulse rising edge.
- States:
  - IDLE:
    - counter held at 0; iTickGap ignored.
    - iTickReSample -> RUN, with slot=0, counter=0, oOverflow=0 and oSat=0.
  - RUN:
    - each edge increments the counter; the counter saturates at 2^CNT_W-1 and sets oSat.
    - on iTickGap:
      - capture {slot, counter + edge_this_cycle} into the output register;
      - counter restarts at 0;
      - slot increments.
    - after capturing slot SLOTS_PER_FRAME-1 -> DONE.
  - DONE:
    - wait until the output register is empty (oSlotValid=0 or the handshake completes this cycle);
    - then pulse oFrameDone for one clock and go to IDLE.
- Output register:
  - a single-entry skid; oSlotData and oSlotValid are registered.
  - oSlotValid rises 1 clock after the capturing iTickGap.
  - While oSlotValid=1 and iSlotReady=0, oSlotData holds stable.
  - oSlotValid drops on the clock after the handshake unless a new capture lands in the same cycle; in that case it stays high with the new data.
- Simultaneous events:
  - Capture while the register is full and not being accepted:
    - the new word is dropped and oOverflow is set;
    - the slot index still increments, so the frame keeps its time alignment.
  - iTickReSample together with iTickGap in RUN or DONE:
    - the resample wins: the frame is aborted and a new one starts with slot=0, counter=0;
    - oFrameDone is not pulsed for the aborted frame;
    - a pending output word is still delivered.
  - iTickReSample in RUN (frame restart): same handling as above.
  - Pulse edge on a tick cycle: counted in the closing slot.
- Arithmetic: all counts unsigned; the slot index compares against SLOTS_PER_FRAME-1 and never exceeds it.

Decomposition:
- Shared package (zpulse_pkg):
  - SLOTS_PER_FRAME, CNT_W and IDX_W defaults;
  - state encoding constants S_IDLE, S_RUN, S_DONE;
  - slot-word field offsets.
- One natural sub-module: zpulse_sync_edge, the SYNC_STAGES synchronizer plus rising-edge detector, producing a one-clock edge strobe.

Test Plan:
- Reset mid-RUN after 10 edges -> all outputs 0, state IDLE, no word emitted, oBusy=0.
- Basic frame:
  - stimulus: iTickReSample, then 7 pulses before the 1st iTickGap and 3 pulses before the 2nd, with iSlotReady=1 throughout;
  - required: words {0,7} and {1,3};
  - after 60 gaps: 60 words with indices 0..59, then one oFrameDone pulse, oBusy=0.
- Backpressure:
  - stimulus: iSlotReady=0 across two gap ticks;
  - required: the first word holds stable, the second is dropped, oOverflow=1;
  - then iSlotReady=1: the first word is accepted and the next word carries index 2.
- Saturation:
  - stimulus: CNT_W=4, 20 pulses in one slot;
  - required: count=15 and oSat=1;
  - the next slot's count starts from 0.
- Edge coincident with iTickGap -> the edge is counted in the closing slot and the new slot starts at 0.
- iTickReSample together with iTickGap at slot 30:
  - required: no oFrameDone and no word for slot 30;
  - the next word is {0,n};
  - oOverflow and oSat are cleared;
  - iTickGap in IDLE produces no word.

Source files
------------

// File: rtl/zpulse_pkg.sv
// Shared defaults, FSM state encoding and slot-word layout for the pulse binner.
package zpulse_pkg;

    localparam int DEF_SLOTS_PER_FRAME = 60;
    localparam int DEF_CNT_W           = 16;
    localparam int DEF_IDX_W           = 6;
    localparam int DEF_SYNC_STAGES     = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Slot word layout: count in the LSBs, slot index directly above it.
    localparam int SW_CNT_LSB = 0;

endpackage

// File: rtl/zpulse_sync_edge.sv
// Multi-stage synchronizer for the asynchronous detector pulse plus a rising-edge
// strobe; the strobe is one clock wide and appears SYNC_STAGES clocks after the pulse.
module zpulse_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iClk,
    input  logic iRst_N,
    input  logic iPulse,
    output logic oEdge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= iPulse;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign oEdge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/zslot_pulse_binner.sv
// Counts detector pulses per 333 us slot and emits one {slot, count} word per slot
// through a single-entry valid/ready output register.
//   state  | meaning
//   S_IDLE | waiting for a resample tick, counter held at 0, gap ticks ignored
//   S_RUN  | counting edges, capturing a slot word on every gap tick
//   S_DONE | last slot captured, waiting for the output register to drain
module zslot_pulse_binner
    import zpulse_pkg::*;
#(
    parameter int SLOTS_PER_FRAME = DEF_SLOTS_PER_FRAME,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int IDX_W           = DEF_IDX_W,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic                   iClk,
    input  logic                   iRst_N,
    input  logic                   iPulse,
    input  logic                   iTickGap,
    input  logic                   iTickReSample,
    output logic [IDX_W+CNT_W-1:0] oSlotData,
    output logic                   oSlotValid,
    input  logic                   iSlotReady,
    output logic                   oFrameDone,
    output logic                   oBusy,
    output logic                   oOverflow,
    output logic                   oSat
);

    localparam int SW_IDX_LSB = SW_CNT_LSB + CNT_W;

    logic                   w_edge;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_cnt_max;
    logic                   w_sat_hit;
    logic                   w_accept;
    logic                   w_room;
    logic                   w_capture;
    logic                   w_last_slot;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_slot;
    logic [IDX_W+CNT_W-1:0] r_data;
    logic                   r_valid;
    logic                   r_frame_done;
    logic                   r_overflow;
    logic                   r_sat;

    zpulse_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .iClk   (iClk),
        .iRst_N (iRst_N),
        .iPulse (iPulse),
        .oEdge  (w_edge)
    );

    always_comb begin
        w_cnt_max   = &r_cnt;
        w_sat_hit   = w_edge & w_cnt_max;
        w_cnt_next  = (w_edge && !w_cnt_max) ? r_cnt + 1'b1 : r_cnt;
        w_accept    = r_valid & iSlotReady;
        w_room      = ~r_valid | w_accept;
        // A resample on the same cycle aborts the frame, so the slot is not captured.
        w_capture   = (r_state == S_RUN) & iTickGap & ~iTickReSample;
        w_last_slot = (r_slot == IDX_W'(SLOTS_PER_FRAME - 1));
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_slot       <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_capture) begin
                if (w_room) begin
                    r_data[SW_IDX_LSB +: IDX_W] <= r_slot;
                    r_data[SW_CNT_LSB +: CNT_W] <= w_cnt_next;
                    r_valid                     <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (iTickReSample) begin
                        r_state    <= S_RUN;
                        r_slot     <= '0;
                        r_overflow <= 1'b0;
                        r_sat      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (iTickReSample) begin
                        r_slot     <= '0;
                        r_cnt      <= '0;
                        r_overflow <= 1'b0;
                        r_sat      <= 1'b0;
                    end else begin
                        if (w_sat_hit) begin
                            r_sat <= 1'b1;
                        end
                        if (iTickGap) begin
                            r_cnt <= '0;
                            if (w_last_slot) begin
                                r_slot  <= '0;
                                r_state <= S_DONE;
                            end else begin
                                r_slot <= r_slot + 1'b1;
                            end
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                    if (iTickReSample) begin
                        r_state    <= S_RUN;
                        r_slot     <= '0;
                        r_overflow <= 1'b0;
                        r_sat      <= 1'b0;
                    end else if (w_room) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oSlotData  = r_data;
    assign oSlotValid = r_valid;
    assign oFrameDone = r_frame_done;
    assign oBusy      = (r_state == S_RUN);
    assign oOverflow  = r_overflow;
    assign oSat       = r_sat;

endmodule

// File: tb/tb_zslot_pulse_binner.sv
// Directed bench for zslot_pulse_binner (CNT_W=4 so saturation is reachable).
module tb_zslot_pulse_binner;

    localparam int CW = 4;
    localparam int IW = 6;

    logic          iClk;
    logic          iRst_N;
    logic          iPulse;
    logic          iTickGap;
    logic          iTickReSample;
    logic [IW+CW-1:0] oSlotData;
    logic          oSlotValid;
    logic          iSlotReady;
    logic          oFrameDone;
    logic          oBusy;
    logic          oOverflow;
    logic          oSat;

    zslot_pulse_binner #(
        .SLOTS_PER_FRAME (60),
        .CNT_W           (CW),
        .IDX_W           (IW),
        .SYNC_STAGES     (2)
    ) dut (
        .iClk          (iClk),
        .iRst_N        (iRst_N),
        .iPulse        (iPulse),
        .iTickGap      (iTickGap),
        .iTickReSample (iTickReSample),
        .oSlotData     (oSlotData),
        .oSlotValid    (oSlotValid),
        .iSlotReady    (iSlotReady),
        .oFrameDone    (oFrameDone),
        .oBusy         (oBusy),
        .oOverflow     (oOverflow),
        .oSat          (oSat)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        int npulse;
        int exp_cnt;
    } vec_t;

    vec_t             vecs[8];
    logic [IW+CW-1:0] q[$];
    int               fd_cnt = 0;
    int               n_checks = 0;
    int               n_fail = 0;

    always @(negedge iClk) begin
        if (oSlotValid && iSlotReady) q.push_back(oSlotData);
        if (oFrameDone) fd_cnt++;
    end

    function automatic logic [IW+CW-1:0] w(input int idx, input int cnt);
        return {IW'(idx), CW'(cnt)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            iPulse = 1'b1;
            cyc(2);
            iPulse = 1'b0;
            cyc(2);
        end
        cyc(2);
    endtask

    task automatic gap();
        iTickGap = 1'b1;
        cyc(1);
        iTickGap = 1'b0;
    endtask

    task automatic resample();
        iTickReSample = 1'b1;
        cyc(1);
        iTickReSample = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int qb;
        int fb;

        vecs[0] = '{7, 7};
        vecs[1] = '{3, 3};
        vecs[2] = '{0, 0};
        vecs[3] = '{1, 1};
        vecs[4] = '{14, 14};
        vecs[5] = '{12, 12};
        vecs[6] = '{2, 2};
        vecs[7] = '{5, 5};

        iRst_N = 1'b0;
        iPulse = 1'b0;
        iTickGap = 1'b0;
        iTickReSample = 1'b0;
        iSlotReady = 1'b1;
        cyc(3);
        chk("rst_valid", oSlotValid, 0);
        chk("rst_data", oSlotData, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_flags", {oFrameDone, oOverflow, oSat}, 0);
        iRst_N = 1'b1;
        cyc(2);

        // Reset in the middle of a running slot
        qb = q.size();
        resample();
        chk("run_busy", oBusy, 1);
        pulses(10);
        iRst_N = 1'b0;
        #2;
        chk("midrst_busy", oBusy, 0);
        chk("midrst_outs", {oSlotValid, oSlotData, oFrameDone, oOverflow, oSat}, 0);
        cyc(1);
        iRst_N = 1'b1;
        cyc(2);
        gap();
        cyc(3);
        chk("idle_gap_no_word", q.size() - qb, 0);
        chk("idle_gap_valid", oSlotValid, 0);

        // Full frame, table-driven slot counts
        qb = q.size();
        fb = fd_cnt;
        resample();
        for (int s = 0; s < 60; s++) begin
            pulses(vecs[s % 8].npulse);
            gap();
            if (s == 0) begin
                chk("first_valid_latency", oSlotValid, 1);
                chk("first_word", oSlotData, w(0, 7));
            end
            cyc(1);
        end
        for (int k = 0; k < 20 && fd_cnt == fb; k++) cyc(1);
        cyc(3);
        chk("frame_words", q.size() - qb, 60);
        for (int i = 0; i < 60; i++) begin
            if (qb + i < q.size()) chk($sformatf("frame_word%0d", i), q[qb + i], w(i, vecs[i % 8].exp_cnt));
        end
        chk("frame_done_cnt", fd_cnt - fb, 1);
        chk("frame_busy", oBusy, 0);
        chk("frame_ovf", oOverflow, 0);

        // Backpressure: second word dropped, index keeps advancing
        qb = q.size();
        resample();
        iSlotReady = 1'b0;
        pulses(2);
        gap();
        chk("bp_first", oSlotData, w(0, 2));
        pulses(4);
        gap();
        chk("bp_ovf", oOverflow, 1);
        chk("bp_hold_valid", oSlotValid, 1);
        cyc(3);
        chk("bp_hold_data", oSlotData, w(0, 2));
        iSlotReady = 1'b1;
        cyc(1);
        chk("bp_drain", oSlotValid, 0);
        pulses(1);
        gap();
        cyc(2);
        chk("bp_words", q.size() - qb, 2);
        if (q.size() - qb == 2) begin
            chk("bp_word0", q[qb], w(0, 2));
            chk("bp_word1", q[qb + 1], w(2, 1));
        end
        chk("bp_ovf_sticky", oOverflow, 1);

        // Saturation (restart also clears the sticky overflow)
        qb = q.size();
        resample();
        chk("restart_ovf_clr", oOverflow, 0);
        pulses(20);
        gap();
        pulses(3);
        gap();
        cyc(2);
        chk("sat_flag", oSat, 1);
        chk("sat_words", q.size() - qb, 2);
        if (q.size() - qb == 2) begin
            chk("sat_word0", q[qb], w(0, 15));
            chk("sat_word1", q[qb + 1], w(1, 3));
        end

        // Edge strobe landing on the gap cycle belongs to the closing slot
        qb = q.size();
        resample();
        pulses(2);
        iPulse = 1'b1;
        cyc(2);
        iTickGap = 1'b1;
        iPulse = 1'b0;
        cyc(1);
        iTickGap = 1'b0;
        cyc(3);
        pulses(1);
        gap();
        cyc(2);
        chk("coinc_words", q.size() - qb, 2);
        if (q.size() - qb == 2) begin
            chk("coinc_word0", q[qb], w(0, 3));
            chk("coinc_word1", q[qb + 1], w(1, 1));
        end

        // Resample together with gap at slot 30
        qb = q.size();
        fb = fd_cnt;
        resample();
        iSlotReady = 1'b0;
        pulses(20);
        gap();
        cyc(1);
        gap();
        iSlotReady = 1'b1;
        cyc(2);
        for (int s = 2; s < 29; s++) begin
            gap();
            cyc(1);
        end
        iSlotReady = 1'b0;
        gap();
        pulses(2);
        chk("pre_abort_flags", {oOverflow, oSat}, 2'b11);
        iTickReSample = 1'b1;
        iTickGap = 1'b1;
        cyc(1);
        iTickReSample = 1'b0;
        iTickGap = 1'b0;
        chk("abort_flags_clr", {oOverflow, oSat}, 0);
        chk("abort_busy", oBusy, 1);
        chk("abort_pending_kept", {oSlotValid, oSlotData}, {1'b1, w(29, 0)});
        iSlotReady = 1'b1;
        cyc(2);
        pulses(4);
        gap();
        cyc(2);
        chk("abort_words", q.size() - qb, 30);
        if (q.size() - qb == 30) begin
            chk("abort_slot0", q[qb], w(0, 15));
            chk("abort_slot2", q[qb + 1], w(2, 0));
            chk("abort_slot29", q[qb + 28], w(29, 0));
            chk("abort_next", q[qb + 29], w(0, 4));
        end
        chk("abort_no_done", fd_cnt - fb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
